systolic_array_os: RTL and testbench
====================================

Name: systolic_array_os

Overview:
- Parametrised, output-stationary, signed ROWS x COLS systolic MAC array with handshaked operand streaming.
- Successor to the fixed 8-bit, always-running square array.
- Adds internal input skewing, job control (start/length), a deterministic flush, and a row-by-row result drain with backpressure.
- Sits between the operand buffers (feature/weight readers) and the activation/writeback stage of the CNN datapath.

Parameters:
- ROWS, 4, PE rows; number of A lanes and of drained result rows.
- COLS, 4, PE columns; number of B lanes and of results per drained row.
- DATA_W, 8, signed operand width.
- ACC_W, 24, signed accumulator width; wraps two's-complement, no saturation.
- K_MAX, 256, maximum reduction length per job.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job start pulse; sampled only in IDLE.
- k_len  in  $clog2(K_MAX+1)  reduction length, sampled with start.
- in_valid  in  1  an A/B beat is present.
- in_ready  out  1  array accepts a beat.
- a_data  in  ROWS*DATA_W  A vector; lane i on bits [(i+1)*DATA_W-1 : i*DATA_W].
- b_data  in  COLS*DATA_W  B vector; same lane packing.
- out_valid  out  1  result row available.
- out_ready  in  1  downstream accepts the row.
- out_data  out  COLS*ACC_W  accumulators of row out_row; column j at lane j.
- out_row  out  $clog2(ROWS)  index of the row currently presented.
- out_last  out  1  high with the row ROWS-1 beat.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, all accumulators and skew/pipeline registers=0, in_ready=0, out_valid=0, out_row=0, out_last=0, busy=0, out_data=0.
- Result definition: C[i][j] = sum over k of A_k[i]*B_k[j]. Products are signed DATA_W x DATA_W, sign-extended to ACC_W, wrapping add.
- FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
- IDLE:
  - start=1 latches k_len, clears all accumulators, beat counter=0.
  - Next state is LOAD if k_len>0, else DRAIN (all results are zero).
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - The array advances every cycle. A cycle with no accepted beat injects zeros into all lanes (bubble), which leaves the sums unchanged.
  - Skew: A lane i is delayed i cycles before PE(i,0); B lane j is delayed j cycles before PE(0,j).
  - A moves right and B moves down one PE per cycle. Each PE does acc += a*b every cycle.
  - After the k_len-th accepted beat: in_ready=0 in the following cycle, and the state moves to FLUSH.
- FLUSH:
  - Zeros are injected for exactly ROWS+COLS-1 cycles; the state then moves to DRAIN.
  - At that point every PE holds its final value.
- DRAIN:
  - out_valid=1, out_row=r, out_data=row r accumulators, starting at r=0.
  - On out_valid && out_ready, r increments; out_last=(r==ROWS-1).
  - While out_ready=0, out_row, out_data and out_last are held stable.
  - After the handshake on row ROWS-1: out_valid=0 in the next cycle, state=IDLE.
  - Accumulators keep their values until the next start.
- Latency (no bubbles, out_ready=1): the first out_valid comes k_len+ROWS+COLS cycles after the start cycle. The job occupies k_len+ROWS+COLS+ROWS cycles in total.
- Reset asserted mid-LOAD, FLUSH or DRAIN: the job is aborted immediately and no partial rows are emitted.
- k_len > K_MAX: behaviour is undefined. The bench must not drive it; an assertion flags it.

Decomposition:
- Shared package cnn_pkg:
  - STATE enum: IDLE, LOAD, FLUSH, DRAIN.
  - Default DATA_W and ACC_W constants.
  - Lane slice helper function.
- Sub-module systolic_pe (DATA_W, ACC_W):
  - Registered a/b pass-through.
  - Signed MAC with synchronous clear.
  - Asynchronous reset.
- The top level holds the skew shift registers, the FSM, the counters and the drain mux.

Test Plan:
- Basic job, defaults: k_len=4, beat k has A=e_k (one-hot lane k) and B=[1,2,3,4]*(k+1). Required: rows 0..3 = [1,2,3,4], [2,4,6,8], [3,6,9,12], [4,8,12,16]; first out_valid exactly 12 cycles after start; out_last only on row 3.
- Signed extremes, k_len=2, all lanes:
  - Beat0 A=-128, B=-128; beat1 A=-128, B=127.
  - Required: every out_data lane = 16384-16256 = 128.
  - Repeat with k_len=1, A=-128, B=127: required -16256.
- Bubbles: repeat the basic job with in_valid toggled 1/0 every cycle. Required: identical results; in_ready falls the cycle after beat 4.
- Backpressure: basic job with out_ready=0 for 5 cycles while row 1 is presented. Required: out_row=1 and out_data=[2,4,6,8] stable throughout; no row skipped or duplicated; 4 handshakes total.
- k_len=0 and ignored start: start with k_len=0. Required: four zero rows; busy returns to 0. A start pulsed during DRAIN has no effect.
- Reset mid-LOAD after beat 2. Required: busy=0, out_valid=0 immediately. A following basic job yields the correct rows with no residue.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath blocks.
// Holds the job-control state encoding and default datapath widths.
package cnn_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bit offset of lane `lane` in a bus packed with `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_array_os_chk.sv
// Protocol checker for systolic_array_os: a job must never request more
// reduction beats than the array was built for.
module systolic_array_os_chk #(
  parameter int K_MAX = 256,
  parameter int K_W   = 9
) (
  input logic           clk,
  input logic           reset,
  input logic           start,
  input logic           idle,
  input logic [K_W-1:0] k_len
);

  k_len_legal: assert property (@(posedge clk) disable iff (reset)
    (start && idle) |-> (32'(k_len) <= 32'(K_MAX)));

endmodule

// File: rtl/systolic_pe.sv
// One output-stationary processing element: registered a/b pass-through
// and a signed multiply-accumulate with a synchronous clear.
module systolic_pe
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
  assign prod_ext = ACC_W'(prod);

  // Operand forwarding and wrapping accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + prod_ext;
      end else begin
        acc <= acc;
      end
    end
  end

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS signed MAC array with input skewing,
// start/length job control, a fixed-length flush and a row-serial drain.
module systolic_array_os
  import cnn_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_MAX  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_W-1:0]       a_data,
  input  logic [COLS*DATA_W-1:0]       b_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLS*ACC_W-1:0]        out_data,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic                         out_last,
  output logic                         busy
);

  localparam int K_W       = $clog2(K_MAX+1);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FL_W      = $clog2(FLUSH_LEN+1);

  state_t            state;
  logic [K_W-1:0]    k_reg;
  logic [K_W-1:0]    beat_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic              accept;
  logic              en;
  logic              clr;

  logic signed [DATA_W-1:0] a_inj  [ROWS];
  logic signed [DATA_W-1:0] a_edge [ROWS];
  logic signed [DATA_W-1:0] b_inj  [COLS];
  logic signed [DATA_W-1:0] b_edge [COLS];
  logic signed [DATA_W-1:0] a_h    [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_v    [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc    [ROWS][COLS];
  logic [COLS*ACC_W-1:0]    acc_row [ROWS];

  assign accept = (state == LOAD) && in_ready && in_valid;
  assign en     = (state == LOAD) || (state == FLUSH);
  assign clr    = (state == IDLE) && start;

  // Non-accepted cycles inject zeros, so bubbles and the flush leave sums unchanged.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
    assign a_inj[i] = accept ? a_data[lane_lsb(i, DATA_W) +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_inj[i];
    end else begin : g_skew
      logic signed [DATA_W-1:0] sr [i];
      // Lane i delay line of i stages.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < i; d++) sr[d] <= '0;
        end else begin
          sr[0] <= a_inj[i];
          for (int d = 1; d < i; d++) sr[d] <= sr[d-1];
        end
      end
      assign a_edge[i] = sr[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_lane
    assign b_inj[j] = accept ? b_data[lane_lsb(j, DATA_W) +: DATA_W] : '0;
    if (j == 0) begin : g_direct
      assign b_edge[j] = b_inj[j];
    end else begin : g_skew
      logic signed [DATA_W-1:0] sr [j];
      // Lane j delay line of j stages.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < j; d++) sr[d] <= '0;
        end else begin
          sr[0] <= b_inj[j];
          for (int d = 1; d < j; d++) sr[d] <= sr[d-1];
        end
      end
      assign b_edge[j] = sr[j-1];
    end
    assign b_v[0][j] = b_edge[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign a_h[i][0] = a_edge[i];
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc[i][j])
      );
      assign acc_row[i][lane_lsb(j, ACC_W) +: ACC_W] = acc[i][j];
    end
  end

  // Job sequencing, counters and the registered drain outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_reg     <= k_len;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            busy      <= 1'b1;
            out_row   <= '0;
            out_data  <= '0;
            if (k_len != '0) begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end else begin
              // Accumulators are cleared on this same edge, so row 0 is zero.
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_last  <= (ROWS == 1);
            end
          end
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + K_W'(1);
            if (beat_cnt + K_W'(1) == k_reg) begin
              in_ready <= 1'b0;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FL_W'(FLUSH_LEN-1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_data  <= acc_row[0];
            out_last  <= (ROWS == 1);
          end else begin
            flush_cnt <= flush_cnt + FL_W'(1);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              out_row   <= '0;
              out_data  <= '0;
            end else begin
              out_row  <= out_row + ROW_W'(1);
              out_data <= acc_row[out_row + ROW_W'(1)];
              out_last <= (out_row + ROW_W'(1) == ROW_W'(ROWS-1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  systolic_array_os_chk #(.K_MAX(K_MAX), .K_W(K_W)) u_chk (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .idle  (state == IDLE),
    .k_len (k_len)
  );

endmodule

// File: tb/tb_systolic_array_os.sv
// Self-checking bench for systolic_array_os: a matrix-product model fills a
// queue of expected rows that one negedge process compares against the DUT.
module tb_systolic_array_os;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int K_MAX  = 256;
  localparam int K_W    = $clog2(K_MAX+1);
  localparam int KB     = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [K_W-1:0]         k_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] a_data;
  logic [COLS*DATA_W-1:0] b_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [COLS*ACC_W-1:0]  out_data;
  logic [1:0]             out_row;
  logic                   out_last;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int beat_a [KB][ROWS];
  int beat_b [KB][COLS];
  int exp_c  [ROWS][COLS];
  logic [COLS*ACC_W-1:0] exp_data_q [$];
  int                    exp_row_q  [$];

  systolic_array_os #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_MAX(K_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_data    (a_data),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // C[i][j] = sum_k A_k[i]*B_k[j], truncated to ACC_W bits per lane.
  task automatic model_job(input int k);
    logic [COLS*ACC_W-1:0] row;
    for (int i = 0; i < ROWS; i++) begin
      row = '0;
      for (int j = 0; j < COLS; j++) begin
        longint s = 0;
        for (int b = 0; b < k; b++) s += longint'(beat_a[b][i]) * longint'(beat_b[b][j]);
        exp_c[i][j] = int'(s);
        row[j*ACC_W +: ACC_W] = ACC_W'(s);
      end
      exp_data_q.push_back(row);
      exp_row_q.push_back(i);
    end
  endtask

  task automatic set_basic();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ROWS; i++) beat_a[k][i] = (i == k) ? 1 : 0;
      for (int j = 0; j < COLS; j++) beat_b[k][j] = (j + 1) * (k + 1);
    end
  endtask

  task automatic set_uniform(input int idx, input int a, input int b);
    for (int i = 0; i < ROWS; i++) beat_a[idx][i] = a;
    for (int j = 0; j < COLS; j++) beat_b[idx][j] = b;
  endtask

  task automatic drive_beat(input int idx);
    for (int i = 0; i < ROWS; i++) a_data[i*DATA_W +: DATA_W] = DATA_W'(beat_a[idx][i]);
    for (int j = 0; j < COLS; j++) b_data[j*DATA_W +: DATA_W] = DATA_W'(beat_b[idx][j]);
  endtask

  task automatic run_job(input int k, input bit bubbles, input bit bp,
                         input bit start_in_drain, input int exp_lat);
    int c0, idx, hs, hold, guard;
    bit tog, took;
    model_job(k);
    start = 1'b1;
    k_len = K_W'(k);
    c0 = cyc;
    tick();
    start = 1'b0;
    idx = 0; tog = 1'b0; guard = 0;
    while (idx < k && guard < 500) begin
      in_valid = !(bubbles && tog);
      drive_beat(idx);
      took = in_valid && (in_ready === 1'b1);
      tick();
      guard++;
      if (took) idx++;
      tog = !tog;
    end
    in_valid = 1'b0;
    if (k > 0) begin
      check_int("beats_accepted", idx, k);
      check("in_ready_drop", 128'(in_ready), 128'(0));
    end
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check("first_valid", 128'(out_valid), 128'(1));
    if (exp_lat >= 0) check_int("latency", cyc - c0, exp_lat);
    hs = 0; hold = 0; guard = 0;
    while (hs < ROWS && guard < 200) begin
      if (bp && out_valid === 1'b1 && out_row == 2'd1 && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      start = start_in_drain && (guard == 1);
      k_len = K_W'(4);
      if (out_valid === 1'b1 && out_ready) hs++;
      tick();
      guard++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check_int("handshakes", hs, ROWS);
    check("valid_after_drain", 128'(out_valid), 128'(0));
    check("busy_after_drain", 128'(busy), 128'(0));
    if (bp) check_int("stall_cycles", hold, 5);
  endtask

  // Every presented row must match the head of the expected-row queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      check("row_expected", 128'(exp_data_q.size() != 0), 128'(1));
      if (exp_data_q.size() != 0) begin
        check("out_data", 128'(out_data), 128'(exp_data_q[0]));
        check("out_row", 128'(out_row), 128'(exp_row_q[0]));
        check("out_last", 128'(out_last), 128'(exp_row_q[0] == ROWS - 1));
        if (out_ready === 1'b1) begin
          void'(exp_data_q.pop_front());
          void'(exp_row_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_data = '0; b_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_row", 128'(out_row), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    reset = 1'b0;
    tick();

    set_basic();
    run_job(4, 1'b0, 1'b0, 1'b0, 12);
    check_int("model_c00", exp_c[0][0], 1);
    check_int("model_c13", exp_c[1][3], 8);
    check_int("model_c21", exp_c[2][1], 6);
    check_int("model_c33", exp_c[3][3], 16);

    set_uniform(0, -128, -128);
    set_uniform(1, -128, 127);
    run_job(2, 1'b0, 1'b0, 1'b0, 10);
    check_int("model_signed_k2", exp_c[2][3], 128);

    set_uniform(0, -128, 127);
    run_job(1, 1'b0, 1'b0, 1'b0, 9);
    check_int("model_signed_k1", exp_c[3][0], -16256);

    set_basic();
    run_job(4, 1'b1, 1'b0, 1'b0, -1);

    set_basic();
    run_job(4, 1'b0, 1'b1, 1'b0, 12);

    run_job(0, 1'b0, 1'b0, 1'b1, -1);
    check_int("model_zero", exp_c[1][2], 0);
    repeat (20) tick();
    check("idle_after_ignored_start", 128'(busy), 128'(0));
    check("no_extra_rows", 128'(out_valid), 128'(0));

    set_basic();
    start = 1'b1; k_len = K_W'(4);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    drive_beat(0);
    tick();
    drive_beat(1);
    tick();
    in_valid = 1'b0;
    check("busy_before_abort", 128'(busy), 128'(1));
    reset = 1'b1;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_in_ready", 128'(in_ready), 128'(0));
    tick();
    reset = 1'b0;
    tick();
    run_job(4, 1'b0, 1'b0, 1'b0, 12);

    repeat (3) tick();
    check_int("queue_drained", exp_data_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
